// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception redirect, data-bus timeout HALT and
// an optional stall-cycle performance counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [1:0]  state_o,
   output logic        timeout_o,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_REFILL = 2'd1,
      ST_HALT   = 2'd2
   } state_t;

   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYC);

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic [7:0] wait_next;
   logic [8:0] wait_inc;
   logic [5:0] stall_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   // Deepest requesting stage wins: everything in front of it is frozen.
   always_comb begin
      stall_req = 6'b000000;
      if (stallreq_mem)
         stall_req = 6'b011111;
      else if (stallreq_ex)
         stall_req = 6'b001111;
      else if (stallreq_id || stallreq_if)
         stall_req = 6'b000111;
   end

   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      stall      = 6'b000000;
      flush      = 1'b0;
      new_pc     = 32'h0000_0000;
      timeout_o  = 1'b0;
      wait_inc   = {1'b0, wait_cnt} + 9'd1;
      if (!rst) begin
         case (state)
            ST_HALT: begin
               stall     = 6'b111111;
               timeout_o = 1'b1;
            end
            default: begin
               if (state == ST_RUN && excepttype_i != 32'h0) begin
                  // Exception beats a coinciding timeout and restarts the wait count.
                  flush      = 1'b1;
                  state_next = ST_REFILL;
                  wait_next  = 8'd0;
                  case (excepttype_i)
                     32'h0000_0001: new_pc = 32'h0000_0020;
                     32'h0000_000e: new_pc = cp0_epc_i;
                     default:       new_pc = 32'h0000_0040;
                  endcase
               end else begin
                  stall      = stall_req;
                  state_next = ST_RUN;
                  if (stallreq_mem) begin
                     wait_next = wait_inc[7:0];
                     if (wait_inc == TIMEOUT_LIM)
                        state_next = ST_HALT;
                  end else begin
                     wait_next = 8'd0;
                  end
               end
            end
         endcase
      end
   end

   assign state_o = state;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= 32'h0;
      else if (state != ST_HALT && stall != 6'b000000 && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 32'h0;
`endif

endmodule
